// File: rtl/fir_pkg.sv
// Shared types and defaults for the folded-FIR round-robin scheduler.
package fir_pkg;
  localparam int N_PHASE_DEF = 4;
  localparam int CTRL_W_DEF  = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fir_rr_sched_if.sv
// Request/grant and datapath-control bundle between channels, scheduler and FIR datapath.
interface fir_rr_sched_if import fir_pkg::*; #(
  parameter int CTRL_W = CTRL_W_DEF
);
  logic              req0;
  logic              req1;
  logic              clr0;
  logic              clr1;
  logic              gnt0;
  logic              gnt1;
  logic              ready;
  logic              x_sel;
  logic              chan_sel;
  logic              x_clr;
  logic              shift;
  logic              y_en;
  logic              y_clr;
  logic [CTRL_W-1:0] ctrl;
  logic              valid;
  logic              y_chan;

  modport master (
    output req0, req1, clr0, clr1,
    input  gnt0, gnt1, ready, x_sel, chan_sel, x_clr, shift, y_en, y_clr,
           ctrl, valid, y_chan
  );

  modport slave (
    input  req0, req1, clr0, clr1,
    output gnt0, gnt1, ready, x_sel, chan_sel, x_clr, shift, y_en, y_clr,
           ctrl, valid, y_chan
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; combinational, zero latency.
// No backpressure: a lone requester always wins, contention goes to the channel not granted last.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_idx,
  output logic gnt_any
);
  assign gnt_any = req0 | req1;
  assign gnt_idx = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/fir_rr_sched.sv
// Two-channel folded-FIR scheduler: grant -> N_PHASE MAC cycles -> valid, N_PHASE+1 cycles grant-to-valid.
// Backpressure: requests/clears are level-held and only sampled in IDLE (ready=1).
module fir_rr_sched import fir_pkg::*; #(
  parameter int N_PHASE = N_PHASE_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fir_rr_sched_if.slave bus
);
  localparam logic [CTRL_W-1:0] CTRL_LAST = CTRL_W'(N_PHASE - 1);

  state_t            state_q;
  state_t            state_d;
  logic              out_en_q;
  logic              lat_ch_q;
  logic              last_q;
  logic [CTRL_W-1:0] ctr_q;

  logic arb_idx;
  logic arb_any;
  logic clr_any;
  logic clr_ch;
  logic take_clr;
  logic take_req;

  rr_arbiter2 u_arb (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // out_en_q holds everything quiet until the first edge after reset release.
  assign clr_any  = bus.clr0 | bus.clr1;
  assign clr_ch   = bus.clr0 ? CH0 : CH1;
  assign take_clr = out_en_q && (state_q == ST_IDLE) && clr_any;
  assign take_req = out_en_q && (state_q == ST_IDLE) && !clr_any && arb_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_clr) begin
          state_d = ST_CLEAR;
        end else if (take_req) begin
          state_d = ST_MAC;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_MAC:   if (ctr_q == CTRL_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_q <= 1'b0;
      lat_ch_q <= CH0;
      last_q   <= CH1;
      ctr_q    <= '0;
    end else begin
      out_en_q <= 1'b1;
      if (take_clr) begin
        lat_ch_q <= clr_ch;
      end
      if (take_req) begin
        lat_ch_q <= arb_idx;
        last_q   <= arb_idx;
      end
      if (state_q == ST_MAC) begin
        ctr_q <= (ctr_q == CTRL_LAST) ? '0 : ctr_q + CTRL_W'(1);
      end
    end
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.x_sel    = 1'b0;
    bus.chan_sel = 1'b0;
    bus.x_clr    = 1'b0;
    bus.shift    = 1'b0;
    bus.y_en     = 1'b0;
    bus.y_clr    = 1'b0;
    bus.ctrl     = '0;
    bus.valid    = 1'b0;
    bus.y_chan   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.ready = out_en_q;
        if (take_req) begin
          bus.gnt0     = (arb_idx == CH0);
          bus.gnt1     = (arb_idx == CH1);
          bus.shift    = 1'b1;
          bus.y_clr    = 1'b1;
          bus.x_sel    = arb_idx;
          bus.chan_sel = arb_idx;
        end
      end
      ST_CLEAR: begin
        bus.x_clr    = 1'b1;
        bus.chan_sel = lat_ch_q;
      end
      ST_MAC: begin
        bus.y_en     = 1'b1;
        bus.ctrl     = ctr_q;
        bus.chan_sel = lat_ch_q;
      end
      ST_DONE: begin
        bus.valid  = 1'b1;
        bus.y_chan = lat_ch_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_rr_sched.sv
// Checks two scheduler instances (4 and 8 phases) against a timeline model of expected output cycles.
module tb_fir_rr_sched;
  typedef struct packed {
    logic       ready, gnt0, gnt1, x_sel, chan_sel, x_clr, shift, y_en, y_clr;
    logic [2:0] ctrl;
    logic       valid, y_chan;
  } ovec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_rr_sched_if #(.CTRL_W(2)) b0 ();
  fir_rr_sched_if #(.CTRL_W(3)) b1 ();

  fir_rr_sched #(.N_PHASE(4), .CTRL_W(2)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  fir_rr_sched #(.N_PHASE(8), .CTRL_W(3)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: per instance, a list of output vectors already committed for upcoming cycles.
  ovec_t sched [2][16];
  int    slen  [2];
  bit    live  [2];
  bit    ptr   [2];

  int gq_cyc[$];
  int gq_ch[$];
  int last_gnt[2];
  int last_val[2];

  task automatic push(input int d, input ovec_t v);
    sched[d][slen[d]] = v;
    slen[d]++;
  endtask

  task automatic model(input int d, input int n, input logic r0, input logic r1,
                       input logic c0, input logic c1, input logic rstv, output ovec_t e);
    ovec_t v;
    bit    w;
    e = '0;
    if (!rstv) begin
      slen[d] = 0;
      live[d] = 1'b0;
      ptr[d]  = 1'b1;
      return;
    end
    if (!live[d]) begin
      live[d] = 1'b1;
      return;
    end
    if (slen[d] > 0) begin
      e = sched[d][0];
      for (int k = 0; k < 15; k++) sched[d][k] = sched[d][k+1];
      slen[d]--;
      return;
    end
    e.ready = 1'b1;
    if (c0 || c1) begin
      v = '0;
      v.x_clr = 1'b1;
      v.chan_sel = c0 ? 1'b0 : 1'b1;
      push(d, v);
    end else if (r0 || r1) begin
      w = (r0 && r1) ? !ptr[d] : r1;
      ptr[d] = w;
      e.gnt0 = !w;
      e.gnt1 = w;
      e.shift = 1'b1;
      e.y_clr = 1'b1;
      e.x_sel = w;
      e.chan_sel = w;
      for (int k = 0; k < n; k++) begin
        v = '0;
        v.y_en = 1'b1;
        v.ctrl = 3'(k);
        v.chan_sel = w;
        push(d, v);
      end
      v = '0;
      v.valid = 1'b1;
      v.y_chan = w;
      push(d, v);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ovec_t e0, e1, o0, o1;
    @(negedge clk);
    o0 = {b0.ready, b0.gnt0, b0.gnt1, b0.x_sel, b0.chan_sel, b0.x_clr, b0.shift,
          b0.y_en, b0.y_clr, 1'b0, b0.ctrl, b0.valid, b0.y_chan};
    o1 = {b1.ready, b1.gnt0, b1.gnt1, b1.x_sel, b1.chan_sel, b1.x_clr, b1.shift,
          b1.y_en, b1.y_clr, b1.ctrl, b1.valid, b1.y_chan};
    model(0, 4, b0.req0, b0.req1, b0.clr0, b0.clr1, rst, e0);
    model(1, 8, b1.req0, b1.req1, b1.clr0, b1.clr1, rst, e1);
    n_chk++;
    assert (o0 === e0) else begin
      n_fail++;
      $error("FAIL outputs_n4 cyc %0d: observed %h expected %h", cyc, o0, e0);
    end
    n_chk++;
    assert (o1 === e1) else begin
      n_fail++;
      $error("FAIL outputs_n8 cyc %0d: observed %h expected %h", cyc, o1, e1);
    end
    if (o0.gnt0 || o0.gnt1) begin
      gq_cyc.push_back(cyc);
      gq_ch.push_back(int'(o0.gnt1));
      last_gnt[0] = cyc;
    end
    if (o0.valid) last_val[0] = cyc;
    if (o1.gnt0 || o1.gnt1) last_gnt[1] = cyc;
    if (o1.valid) last_val[1] = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int rel, saved_val, ones;
    last_gnt = '{-100, -100};
    last_val = '{-100, -100};
    rst = 1'b0;
    b0.req0 = 0; b0.req1 = 0; b0.clr0 = 0; b0.clr1 = 0;
    b1.req0 = 0; b1.req1 = 0; b1.clr0 = 0; b1.clr1 = 0;
    ticks(3);

    // Single held request straight out of reset; a stray req1 pulse mid-MAC.
    rst = 1'b1;
    b0.req0 = 1'b1;
    rel = cyc;
    ticks(2);
    chk("first_gnt_cycle", last_gnt[0], rel + 1);
    ticks(2);
    b0.req1 = 1'b1;
    tick();
    b0.req1 = 1'b0;
    ticks(2);
    chk("latency_n4", last_val[0] - last_gnt[0], 5);
    ones = 0;
    foreach (gq_ch[i]) ones += gq_ch[i];
    chk("req1_pulse_ignored", ones, 0);

    // Clear of channel 1 beats the held req0; grant follows the CLEAR cycle.
    b0.clr1 = 1'b1;
    tick();
    b0.clr1 = 1'b0;
    ticks(2);
    chk("gnt_after_clear", last_gnt[0], cyc - 1);

    // Reset at ctrl=2 aborts the sample; pointer returns to 1.
    ticks(2);
    saved_val = last_val[0];
    rst = 1'b0;
    b0.req1 = 1'b1;
    ticks(3);
    chk("no_valid_after_abort", last_val[0], saved_val);

    gq_cyc.delete();
    gq_ch.delete();
    rst = 1'b1;
    ticks(26);
    chk("grant_count", int'(gq_ch.size() >= 4), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_ch%0d", i), gq_ch[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("spacing%0d", i), gq_cyc[i] - gq_cyc[i-1], 6);
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    ticks(8);

    // Eight-phase instance, single request.
    b1.req0 = 1'b1;
    tick();
    b1.req0 = 1'b0;
    ticks(10);
    chk("gnt_seen_n8", int'(last_gnt[1] >= 0), 1);
    chk("latency_n8", last_val[1] - last_gnt[1], 9);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) != 0);
      b0.req0 = $urandom_range(1); b0.req1 = $urandom_range(1);
      b1.req0 = $urandom_range(1); b1.req1 = $urandom_range(1);
      b0.clr0 = ($urandom_range(7) == 0); b0.clr1 = ($urandom_range(7) == 0);
      b1.clr0 = ($urandom_range(7) == 0); b1.clr1 = ($urandom_range(7) == 0);
      tick();
    end
    rst = 1'b1;
    b0.req0 = 0; b0.req1 = 0; b0.clr0 = 0; b0.clr1 = 0;
    b1.req0 = 0; b1.req1 = 0; b1.clr0 = 0; b1.clr1 = 0;
    ticks(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_rr_sched.md
FIR_RR_SCHED -- requirements
Module: fir_rr_sched

Interface
REQ-001 The block SHALL have parameter N_PHASE, default 4, meaning folded MAC phases per output sample (ctrl counts 0..N_PHASE-1).
REQ-002 The block SHALL have parameter CTRL_W, default 2, meaning the width of ctrl, equal to clog2(N_PHASE).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0, req1  input  1 each  meaning the channel has a sample on its x input, held until granted.
REQ-006 The block SHALL have ports clr0, clr1  input  1 each  meaning a request to clear that channel's delay line.
REQ-007 The block SHALL have ports gnt0, gnt1  output  1 each  meaning a one-cycle acceptance of that channel's sample.
REQ-008 The block SHALL have port ready  output  1  meaning the scheduler is in IDLE and can grant this cycle.
REQ-009 The block SHALL have ports x_sel, chan_sel  output  1 each  meaning the datapath input mux select and the delay-line bank select.
REQ-010 The block SHALL have ports x_clr, shift, y_en, y_clr  output  1 each  meaning the datapath controls.
REQ-011 The block SHALL have port ctrl  output  CTRL_W  meaning the coefficient/tap pair select.
REQ-012 The block SHALL have ports valid, y_chan  output  1 each  meaning y is final for the channel given by y_chan.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, MAC and DONE.
REQ-014 In IDLE with clr0 or clr1 high, the FSM SHALL go to CLEAR; clear SHALL take priority over any request, and clr0 SHALL take priority over clr1.
REQ-015 CLEAR SHALL last one cycle, with x_clr=1 and chan_sel set to the cleared channel, and SHALL then return to IDLE.
REQ-016 In IDLE with no clear and at least one request, the FSM SHALL grant one channel in that cycle: gnt_i=1, shift=1, y_clr=1, x_sel=chan_sel=i.
REQ-017 The granted channel SHALL be latched, and the FSM SHALL then enter MAC.
REQ-018 Arbitration SHALL be round-robin: when both channels request, the channel not granted last wins; a single requester always wins.
REQ-019 The last-granted pointer SHALL reset to 1, so channel 0 wins the first contention.
REQ-020 MAC SHALL last exactly N_PHASE cycles, with y_en=1, ctrl=0,1,..,N_PHASE-1 and chan_sel held at the latched channel.
REQ-021 DONE SHALL last one cycle, with valid=1 and y_chan set to the latched channel, and SHALL then return to IDLE.
REQ-022 Latency from grant cycle to valid SHALL be N_PHASE+1 cycles; minimum sample spacing SHALL be N_PHASE+2 cycles.
REQ-023 Requests and clears arriving outside IDLE SHALL be ignored until IDLE; they are level signals and are not lost while held.
REQ-024 ready SHALL be 1 only in IDLE.
REQ-025 Outside the states that drive them, gnt*, shift, y_clr, y_en, x_clr and valid SHALL be 0 and ctrl SHALL be 0.
REQ-026 At most one gnt SHALL be high in any cycle.
REQ-027 The ctrl counter SHALL wrap to 0 on MAC exit; it SHALL never exceed N_PHASE-1.

Reset
REQ-028 While rst=0, the state SHALL be IDLE, the latched channel 0, the pointer 1 and ctrl 0.
REQ-029 While rst=0, all outputs SHALL be 0, including ready.
REQ-030 ready SHALL rise in the first cycle after rst deasserts.
REQ-031 Reset during MAC or DONE SHALL abort the sample with no valid pulse.

Structure
REQ-032 Package fir_pkg SHALL hold the state enum, N_PHASE and CTRL_W defaults, and channel-index constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req0, req1, last pointer; outputs grant index and any-grant).
REQ-034 No other sub-modules SHALL be used.

Verification
REQ-035 The bench SHALL cover: after reset, req0=1 held -> gnt0 one cycle after reset release, ctrl 0,1,2,3 with y_en=1, then valid=1 and y_chan=0 exactly 5 cycles after gnt0.
REQ-036 The bench SHALL cover: req0=req1=1 held for 4 samples -> grants alternate 0,1,0,1, each separated by 6 cycles.
REQ-037 The bench SHALL cover: clr1=1 and req0=1 together in IDLE -> CLEAR cycle with x_clr=1 and chan_sel=1, then gnt0 on the next cycle.
REQ-038 The bench SHALL cover: rst pulled low at ctrl=2 of a sample -> all outputs 0 immediately, no valid for that sample, and the pointer reset so ch0 wins the next contention.
REQ-039 The bench SHALL cover: req1 pulsed for one cycle during MAC -> no gnt1 and no effect on the current sequence.
REQ-040 The bench SHALL cover: N_PHASE=8 (CTRL_W=3) with a single request -> ctrl 0..7, then valid 9 cycles after the grant.
